lc4_wb_arbiter: RTL and testbench

LC4_WB_ARBITER -- requirements
Module: lc4_wb_arbiter

---
 rtl/lc4_wb_arbiter_pkg.sv | 22 ++
 rtl/lc4_wb_fifo.sv | 92 +++++++++
 rtl/lc4_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_lc4_wb_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lc4_wb_arbiter_pkg.sv
// Shared definitions for the LC4 write-back arbiter.
// Holds the sequence-tag width, per-source FIFO depth, register count and the
// modular age compare used to order entries from the two pipes.
package lc4_wb_arbiter_pkg;

  localparam int unsigned TagW      = 3;
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned NumRegs   = 8;
  localparam int unsigned RdW       = $clog2(NumRegs);

  typedef logic [TagW-1:0] tag_t;
  typedef logic [RdW-1:0]  rd_t;

  // True when tag a was issued before tag b. At most 2*FifoDepth entries are
  // outstanding, so a forward distance of 1..3 means older even across a wrap.
  function automatic logic tag_older(input tag_t a, input tag_t b);
    tag_t diff;
    diff = b - a;
    return (diff != '0) && (diff < tag_t'(FifoDepth * 2));
  endfunction

endpackage

// File: rtl/lc4_wb_fifo.sv
// Two-entry FIFO holding pending register-file writes for one pipe.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_*_i        enqueue strobe and entry (rd, data, tag); ignored when full
//   pop_i           dequeue the head; ignored when empty
//   full_o          two entries held
//   head_*_o        head entry, valid when head_valid_o
//   pending_o       one-hot OR of destinations of all held entries
module lc4_wb_fifo
  import lc4_wb_arbiter_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  rd_t                push_rd_i,
  input  logic [n-1:0]       push_data_i,
  input  tag_t               push_tag_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               head_valid_o,
  output rd_t                head_rd_o,
  output logic [n-1:0]       head_data_o,
  output tag_t               head_tag_o,
  output logic [NumRegs-1:0] pending_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  rd_t            rd_q   [FifoDepth];
  rd_t            rd_d   [FifoDepth];
  logic [n-1:0]   data_q [FifoDepth];
  logic [n-1:0]   data_d [FifoDepth];
  tag_t           tag_q  [FifoDepth];
  tag_t           tag_d  [FifoDepth];
  logic [CntW-1:0] count_q, count_d;

  logic push_ok, pop_ok, wr_idx;

  assign full_o       = (count_q == CntW'(FifoDepth));
  assign head_valid_o = (count_q != '0);
  assign head_rd_o    = rd_q[0];
  assign head_data_o  = data_q[0];
  assign head_tag_o   = tag_q[0];

  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    tag_d   = tag_q;
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && head_valid_o;
    // Slot 0 is always the head; a pop shifts slot 1 down.
    if (pop_ok) begin
      rd_d[0]   = rd_q[1];
      data_d[0] = data_q[1];
      tag_d[0]  = tag_q[1];
    end
    // Push lands behind whatever survives the pop (count 1 with pop -> slot 0).
    wr_idx = (count_q == CntW'(1)) && !pop_ok;
    if (push_ok) begin
      rd_d[wr_idx]   = push_rd_i;
      data_d[wr_idx] = push_data_i;
      tag_d[wr_idx]  = push_tag_i;
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < int'(FifoDepth); i++) begin
      if (i < int'(count_q)) pending_o[rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/lc4_wb_arbiter.sv
// Merges register-file writes from two pipes (A older, B younger) into one
// write port. Each pipe feeds a private 2-entry FIFO; entries carry a shared
// sequence tag so the oldest head is always written first. Equal-destination
// heads are retired together and only the younger data is written.
// Ports:
//   clk, rst, gwe             clock, async active-high reset, global write enable
//   i_x_valid/rd/data, o_x_ready  per-source write handshake (x = a, b)
//   o_rd, o_wdata, o_rd_we    register-file write port (zeroed when idle)
//   o_pending                 one-hot destinations of all buffered entries
module lc4_wb_arbiter
  import lc4_wb_arbiter_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic         i_a_valid,
  input  logic [2:0]   i_a_rd,
  input  logic [n-1:0] i_a_data,
  output logic         o_a_ready,
  input  logic         i_b_valid,
  input  logic [2:0]   i_b_rd,
  input  logic [n-1:0] i_b_data,
  output logic         o_b_ready,
  output logic [2:0]   o_rd,
  output logic [n-1:0] o_wdata,
  output logic         o_rd_we,
  output logic [7:0]   o_pending
);

  tag_t tag_q, tag_d, a_tag, b_tag;
  logic a_push, b_push, a_pop, b_pop, a_full, b_full, a_hv, b_hv, a_older;
  rd_t  a_hrd, b_hrd;
  tag_t a_htag, b_htag;
  logic [n-1:0] a_hdata, b_hdata;
  logic [NumRegs-1:0] a_pend, b_pend;

  // Ready depends only on stored count, never on this cycle's pop.
  assign o_a_ready = gwe && !a_full;
  assign o_b_ready = gwe && !b_full;
  assign a_push    = i_a_valid && o_a_ready;
  assign b_push    = i_b_valid && o_b_ready;

  // A is the older pipe, so it takes the lower tag on a simultaneous accept.
  assign a_tag = tag_q;
  assign b_tag = tag_q + tag_t'(a_push);
  assign tag_d = tag_q + tag_t'(a_push) + tag_t'(b_push);

  assign o_pending = a_pend | b_pend;

  lc4_wb_fifo #(.n(n)) u_fifo_a (
    .clk          (clk),
    .rst          (rst),
    .push_i       (a_push),
    .push_rd_i    (i_a_rd),
    .push_data_i  (i_a_data),
    .push_tag_i   (a_tag),
    .pop_i        (a_pop),
    .full_o       (a_full),
    .head_valid_o (a_hv),
    .head_rd_o    (a_hrd),
    .head_data_o  (a_hdata),
    .head_tag_o   (a_htag),
    .pending_o    (a_pend)
  );

  lc4_wb_fifo #(.n(n)) u_fifo_b (
    .clk          (clk),
    .rst          (rst),
    .push_i       (b_push),
    .push_rd_i    (i_b_rd),
    .push_data_i  (i_b_data),
    .push_tag_i   (b_tag),
    .pop_i        (b_pop),
    .full_o       (b_full),
    .head_valid_o (b_hv),
    .head_rd_o    (b_hrd),
    .head_data_o  (b_hdata),
    .head_tag_o   (b_htag),
    .pending_o    (b_pend)
  );

  always_comb begin
    a_pop   = 1'b0;
    b_pop   = 1'b0;
    o_rd_we = 1'b0;
    o_rd    = '0;
    o_wdata = '0;
    a_older = tag_older(a_htag, b_htag);
    if (gwe) begin
      if (a_hv && b_hv) begin
        o_rd_we = 1'b1;
        if (a_hrd == b_hrd) begin
          // WAW: the older write is dead, retire both and keep the younger data.
          a_pop   = 1'b1;
          b_pop   = 1'b1;
          o_rd    = a_hrd;
          o_wdata = a_older ? b_hdata : a_hdata;
        end else if (a_older) begin
          a_pop   = 1'b1;
          o_rd    = a_hrd;
          o_wdata = a_hdata;
        end else begin
          b_pop   = 1'b1;
          o_rd    = b_hrd;
          o_wdata = b_hdata;
        end
      end else if (a_hv) begin
        a_pop   = 1'b1;
        o_rd_we = 1'b1;
        o_rd    = a_hrd;
        o_wdata = a_hdata;
      end else if (b_hv) begin
        b_pop   = 1'b1;
        o_rd_we = 1'b1;
        o_rd    = b_hrd;
        o_wdata = b_hdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (gwe) begin
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_lc4_wb_arbiter.sv
module tb_lc4_wb_arbiter;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } wr_t;

  logic        clk, rst, gwe;
  logic        i_a_valid, i_b_valid, o_a_ready, o_b_ready, o_rd_we;
  logic [2:0]  i_a_rd, i_b_rd, o_rd;
  logic [15:0] i_a_data, i_b_data, o_wdata;
  logic [7:0]  o_pending;

  int  checks   = 0;
  int  failures = 0;
  wr_t sb[$];
  int  a_low, b_low;

  lc4_wb_arbiter #(.n(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .gwe       (gwe),
    .i_a_valid (i_a_valid),
    .i_a_rd    (i_a_rd),
    .i_a_data  (i_a_data),
    .o_a_ready (o_a_ready),
    .i_b_valid (i_b_valid),
    .i_b_rd    (i_b_rd),
    .i_b_data  (i_b_data),
    .o_b_ready (o_b_ready),
    .o_rd      (o_rd),
    .o_wdata   (o_wdata),
    .o_rd_we   (o_rd_we),
    .o_pending (o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks outputs against the scoreboard, then records accepted transfers.
  // Buffered entries equal the scoreboard contents, so pending and write-enable
  // follow from it directly.
  task automatic sample(input bit manual_push);
    logic [7:0] pend;
    wr_t e;
    #1;
    pend = '0;
    foreach (sb[i]) pend[sb[i].rd] = 1'b1;
    chk("pending", {24'd0, o_pending}, {24'd0, pend});
    chk("rd_we", {31'd0, o_rd_we}, {31'd0, (gwe && !rst && sb.size() != 0)});
    if (o_rd_we && sb.size() != 0) begin
      e = sb.pop_front();
      chk("wr_rd", {29'd0, o_rd}, {29'd0, e.rd});
      chk("wr_data", {16'd0, o_wdata}, {16'd0, e.data});
    end else if (!o_rd_we) begin
      chk("idle_rd", {29'd0, o_rd}, 32'd0);
      chk("idle_data", {16'd0, o_wdata}, 32'd0);
    end
    if (!manual_push) begin
      if (i_a_valid && o_a_ready) sb.push_back('{rd: i_a_rd, data: i_a_data});
      if (i_b_valid && o_b_ready) sb.push_back('{rd: i_b_rd, data: i_b_data});
    end
  endtask

  initial begin
    rst = 1'b1; gwe = 1'b0;
    i_a_valid = 1'b0; i_a_rd = '0; i_a_data = '0;
    i_b_valid = 1'b0; i_b_rd = '0; i_b_data = '0;

    // Reset state
    tick();
    sample(1'b0);
    chk("rst_a_ready", {31'd0, o_a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, o_b_ready}, 32'd0);
    rst = 1'b0; gwe = 1'b1;
    tick();
    sample(1'b0);
    chk("idle_a_ready", {31'd0, o_a_ready}, 32'd1);
    chk("idle_b_ready", {31'd0, o_b_ready}, 32'd1);

    // Two different destinations in one cycle: A first, then B
    i_a_valid = 1'b1; i_a_rd = 3'd3; i_a_data = 16'h1111;
    i_b_valid = 1'b1; i_b_rd = 3'd5; i_b_data = 16'h2222;
    sample(1'b0);
    tick();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    sample(1'b0);
    chk("p31_pend_after_a", {24'd0, o_pending}, 32'h28);
    tick();
    sample(1'b0);
    tick();
    sample(1'b0);
    tick();

    // Same destination in one cycle: only B's data is written
    i_a_valid = 1'b1; i_a_rd = 3'd2; i_a_data = 16'hAAAA;
    i_b_valid = 1'b1; i_b_rd = 3'd2; i_b_data = 16'hBBBB;
    sample(1'b1);
    chk("waw_a_ready", {31'd0, o_a_ready}, 32'd1);
    chk("waw_b_ready", {31'd0, o_b_ready}, 32'd1);
    sb.push_back('{rd: 3'd2, data: 16'hBBBB});
    tick();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    sample(1'b0);
    tick();
    sample(1'b0);
    tick();

    // Both sources stream; tags wrap several times
    a_low = 0; b_low = 0;
    i_a_valid = 1'b1; i_b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_a_rd = 3'(i % 4);     i_a_data = 16'hA000 + 16'(i);
      i_b_rd = 3'(4 + i % 4); i_b_data = 16'hB000 + 16'(i);
      sample(1'b0);
      if (!o_a_ready) a_low++;
      if (!o_b_ready) b_low++;
      tick();
    end
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample(1'b0);
      tick();
    end
    chk("stream_drained", sb.size(), 32'd0);
    chk("stream_a_backpressure", {31'd0, (a_low != 0)}, 32'd1);
    chk("stream_b_backpressure", {31'd0, (b_low != 0)}, 32'd1);

    // gwe held low with two entries buffered
    i_a_valid = 1'b1; i_a_rd = 3'd1; i_a_data = 16'h0101;
    i_b_valid = 1'b1; i_b_rd = 3'd6; i_b_data = 16'h0606;
    sample(1'b0);
    tick();
    gwe = 1'b0;
    i_a_rd = 3'd0; i_a_data = 16'hDEAD;
    i_b_rd = 3'd7; i_b_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      sample(1'b0);
      chk("gwe0_a_ready", {31'd0, o_a_ready}, 32'd0);
      chk("gwe0_b_ready", {31'd0, o_b_ready}, 32'd0);
      chk("gwe0_pending", {24'd0, o_pending}, 32'h42);
      tick();
    end
    gwe = 1'b1; i_a_valid = 1'b0; i_b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(1'b0);
      tick();
    end

    // Asynchronous reset between edges with two entries buffered
    i_a_valid = 1'b1; i_a_rd = 3'd4; i_a_data = 16'h4444;
    i_b_valid = 1'b1; i_b_rd = 3'd7; i_b_data = 16'h7777;
    sample(1'b0);
    tick();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_we", {31'd0, o_rd_we}, 32'd0);
    chk("arst_rd", {29'd0, o_rd}, 32'd0);
    chk("arst_wdata", {16'd0, o_wdata}, 32'd0);
    chk("arst_pending", {24'd0, o_pending}, 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
